note_sequencer: RTL and testbench

Programmable 8-step note sequencer that drives the note-select and enable inputs of the square wave generator. It replaces the free-running step counter with a play/pause/stop FSM. Each step holds a note index, a duration in tempo ticks, and a rest flag. A fixed silent gap separates consecutive notes, and playback can loop.

---
 rtl/note_sequencer_if.sv | 39 +++
 rtl/note_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_note_sequencer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/note_sequencer_if.sv
// note_sequencer_if
//   Groups the command, pattern-write and playback-status signals of the
//   note sequencer into one bundle.
//   master : drives commands and pattern writes, observes playback status
//   slave  : the sequencer itself
//   Commands : start, stop, pause (1-cycle pulses), loop (level)
//   Writes   : wr_en, wr_addr, wr_note, wr_dur, wr_rest
//   Status   : note, gate, step, busy, done, state
interface note_sequencer_if #(
  parameter int DUR_W = 8
);
  logic             start;
  logic             stop;
  logic             pause;
  logic             loop;
  logic             wr_en;
  logic [2:0]       wr_addr;
  logic [2:0]       wr_note;
  logic [DUR_W-1:0] wr_dur;
  logic             wr_rest;
  logic [2:0]       note;
  logic             gate;
  logic [2:0]       step;
  logic             busy;
  logic             done;
  logic [1:0]       state;

  modport master (
    output start, stop, pause, loop,
    output wr_en, wr_addr, wr_note, wr_dur, wr_rest,
    input  note, gate, step, busy, done, state
  );

  modport slave (
    input  start, stop, pause, loop,
    input  wr_en, wr_addr, wr_note, wr_dur, wr_rest,
    output note, gate, step, busy, done, state
  );
endinterface

// File: rtl/note_sequencer.sv
// note_sequencer
//   Programmable step sequencer feeding the note-select and enable inputs of
//   the square wave generator. Each pattern step holds a note index, a
//   duration in tempo ticks and a rest flag; every step is followed by a
//   fixed silent gap. Playback is controlled by a play/gap/pause/idle FSM.
//   Ports:
//     CLOCK_50 : system clock
//     reset    : synchronous, active-high reset
//     bus      : slave side of note_sequencer_if (commands, pattern writes,
//                note/gate/step/busy/done/state status)
module note_sequencer #(
  parameter int TICK_DIV  = 50000,
  parameter int STEPS     = 8,
  parameter int DUR_W     = 8,
  parameter int GAP_TICKS = 2
) (
  input logic             CLOCK_50,
  input logic             reset,
  note_sequencer_if.slave bus
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam int AW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  localparam logic [2:0]       LAST_STEP = 3'(STEPS - 1);
  localparam logic [PRE_W-1:0] PRE_MAX   = PRE_W'(TICK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_INIT  = GAP_W'(GAP_TICKS);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    PLAY   = 2'b01,
    GAP    = 2'b10,
    PAUSED = 2'b11
  } state_t;

  state_t           state_q, state_d;
  state_t           ret_q, ret_d;
  logic [PRE_W-1:0] presc_q, presc_d;
  logic [DUR_W-1:0] dur_cnt_q, dur_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [2:0]       step_q, step_d;
  logic [2:0]       note_q, note_d;
  logic             gate_q, gate_d;
  logic             rest_q, rest_d;
  logic             done_q, done_d;

  logic [2:0]       mem_note_q [STEPS];
  logic [2:0]       mem_note_d [STEPS];
  logic [DUR_W-1:0] mem_dur_q  [STEPS];
  logic [DUR_W-1:0] mem_dur_d  [STEPS];
  logic             mem_rest_q [STEPS];
  logic             mem_rest_d [STEPS];

  logic             running;
  logic             tick;
  logic             do_load;
  logic             do_advance;
  logic [2:0]       load_idx;
  logic [AW-1:0]    load_addr;

  // The prescaler only runs while a note or gap is being timed, so a paused
  // sequence keeps its position within the current tick.
  assign running   = (state_q == PLAY) || (state_q == GAP);
  assign tick      = running && (presc_q == PRE_MAX);
  assign load_addr = load_idx[AW-1:0];

  // Pattern RAM: at most one entry written per cycle. Loads read the _q
  // contents, so a same-cycle write to the loaded address is seen only on
  // the next visit to that step.
  always_comb begin
    mem_note_d = mem_note_q;
    mem_dur_d  = mem_dur_q;
    mem_rest_d = mem_rest_q;
    if (bus.wr_en) begin
      mem_note_d[bus.wr_addr[AW-1:0]] = bus.wr_note;
      mem_dur_d[bus.wr_addr[AW-1:0]]  = bus.wr_dur;
      mem_rest_d[bus.wr_addr[AW-1:0]] = bus.wr_rest;
    end
  end

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    presc_d    = presc_q;
    dur_cnt_d  = dur_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    step_d     = step_q;
    note_d     = note_q;
    gate_d     = gate_q;
    rest_d     = rest_q;
    done_d     = 1'b0;
    do_load    = 1'b0;
    do_advance = 1'b0;
    load_idx   = 3'd0;

    if (running) begin
      presc_d = tick ? '0 : presc_q + PRE_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          do_load  = 1'b1;
          load_idx = 3'd0;
          presc_d  = '0;
        end
      end
      PLAY: begin
        if (tick) begin
          if (dur_cnt_q == DUR_W'(1)) begin
            if (GAP_TICKS > 0) begin
              state_d   = GAP;
              gap_cnt_d = GAP_INIT;
              gate_d    = 1'b0;
            end else begin
              do_advance = 1'b1;
            end
          end else begin
            dur_cnt_d = dur_cnt_q - DUR_W'(1);
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (gap_cnt_q == GAP_W'(1)) begin
            do_advance = 1'b1;
          end else begin
            gap_cnt_d = gap_cnt_q - GAP_W'(1);
          end
        end
      end
      PAUSED: begin
        if (bus.start || bus.pause) begin
          state_d = ret_q;
          gate_d  = (ret_q == PLAY) && !rest_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (do_advance) begin
      if (step_q < LAST_STEP) begin
        do_load  = 1'b1;
        load_idx = step_q + 3'd1;
      end else if (bus.loop) begin
        do_load  = 1'b1;
        load_idx = 3'd0;
      end else begin
        state_d = IDLE;
        done_d  = 1'b1;
        step_d  = 3'd0;
        gate_d  = 1'b0;
      end
    end

    // A zero duration would never reach the last-tick compare, so it plays
    // as a single tick.
    if (do_load) begin
      state_d   = PLAY;
      step_d    = load_idx;
      note_d    = mem_note_q[load_addr];
      dur_cnt_d = (mem_dur_q[load_addr] == '0) ? DUR_W'(1) : mem_dur_q[load_addr];
      rest_d    = mem_rest_q[load_addr];
      gate_d    = !mem_rest_q[load_addr];
    end

    // The cycle in which pause arrives still counts as played time; the
    // state it would have moved to becomes the resume target. start has
    // priority over pause and is a no-op while playing.
    if (running && bus.pause && !bus.start && (state_d != IDLE)) begin
      ret_d   = state_d;
      state_d = PAUSED;
      gate_d  = 1'b0;
    end

    if (bus.stop && (state_q != IDLE)) begin
      state_d = IDLE;
      gate_d  = 1'b0;
      step_d  = 3'd0;
      note_d  = 3'd0;
      done_d  = 1'b0;
      presc_d = '0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= IDLE;
      ret_q     <= PLAY;
      presc_q   <= '0;
      dur_cnt_q <= '0;
      gap_cnt_q <= '0;
      step_q    <= 3'd0;
      note_q    <= 3'd0;
      gate_q    <= 1'b0;
      rest_q    <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < STEPS; i++) begin
        mem_note_q[i] <= 3'(i);
        mem_dur_q[i]  <= DUR_W'(8);
        mem_rest_q[i] <= 1'b0;
      end
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      presc_q    <= presc_d;
      dur_cnt_q  <= dur_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      step_q     <= step_d;
      note_q     <= note_d;
      gate_q     <= gate_d;
      rest_q     <= rest_d;
      done_q     <= done_d;
      mem_note_q <= mem_note_d;
      mem_dur_q  <= mem_dur_d;
      mem_rest_q <= mem_rest_d;
    end
  end

  assign bus.note  = note_q;
  assign bus.gate  = gate_q;
  assign bus.step  = step_q;
  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = done_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer
//   Self-checking bench for note_sequencer. A behavioural model tracks the
//   playing step as a position inside its expanded timeline
//   (dur*TICK_DIV gate cycles followed by GAP_TICKS*TICK_DIV silent cycles)
//   and predicts every output after every clock edge.
module tb_note_sequencer;

  localparam int TICK_DIV  = 4;
  localparam int STEPS     = 8;
  localparam int DUR_W     = 8;
  localparam int GAP_TICKS = 2;

  logic CLOCK_50 = 1'b0;
  logic reset;

  always #5 CLOCK_50 = ~CLOCK_50;

  note_sequencer_if #(.DUR_W(DUR_W)) bus ();

  note_sequencer #(
    .TICK_DIV (TICK_DIV),
    .STEPS    (STEPS),
    .DUR_W    (DUR_W),
    .GAP_TICKS(GAP_TICKS)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .bus     (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int done_count  = 0;
  int last_done   = -1;

  // Model: mode 0 = idle, 1 = running, 2 = paused.
  int m_note [STEPS];
  int m_dur  [STEPS];
  bit m_rest [STEPS];
  int mode, pos, play_len, step_len, cur_step, cur_note;
  bit cur_rest, exp_done;

  task automatic model_load(input int k);
    int d;
    d        = (m_dur[k] == 0) ? 1 : m_dur[k];
    cur_step = k;
    cur_note = m_note[k];
    cur_rest = m_rest[k];
    play_len = d * TICK_DIV;
    step_len = (d + GAP_TICKS) * TICK_DIV;
    pos      = 0;
    mode     = 1;
  endtask

  task automatic model_update();
    exp_done = 1'b0;
    if (reset) begin
      mode     = 0;
      cur_step = 0;
      cur_note = 0;
      for (int i = 0; i < STEPS; i++) begin
        m_note[i] = i;
        m_dur[i]  = 8;
        m_rest[i] = 1'b0;
      end
    end else begin
      if (bus.stop && mode != 0) begin
        mode     = 0;
        cur_step = 0;
        cur_note = 0;
      end else if (mode == 0) begin
        if (bus.start) model_load(0);
      end else if (mode == 1) begin
        pos++;
        if (pos == step_len) begin
          if (cur_step < STEPS - 1) model_load(cur_step + 1);
          else if (bus.loop) model_load(0);
          else begin
            mode     = 0;
            cur_step = 0;
            exp_done = 1'b1;
          end
        end
        if (mode == 1 && bus.pause && !bus.start) mode = 2;
      end else if (bus.start || bus.pause) begin
        mode = 1;
      end
      if (bus.wr_en) begin
        m_note[bus.wr_addr] = int'(bus.wr_note);
        m_dur[bus.wr_addr]  = int'(bus.wr_dur);
        m_rest[bus.wr_addr] = bus.wr_rest;
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [1:0]  e_state;
    logic        e_gate;
    logic [10:0] expv, obs;
    case (mode)
      0:       e_state = 2'b00;
      1:       e_state = (pos < play_len) ? 2'b01 : 2'b10;
      default: e_state = 2'b11;
    endcase
    e_gate = (mode == 1) && (pos < play_len) && !cur_rest;
    expv = {e_state, (mode != 0), exp_done, e_gate, 3'(cur_step), 3'(cur_note)};
    obs  = {bus.state, bus.busy, bus.done, bus.gate, bus.step, bus.note};
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s cycle %0d: observed {state,busy,done,gate,step,note}=%b required %b",
             tag, cyc, obs, expv);
    end
  endtask

  task automatic checkValue(input string tag, input int observed, input int required);
    vectors++;
    assert (observed === required) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d required %0d", tag, observed, required);
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge CLOCK_50);
    #1;
    cyc++;
    model_update();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.pause = 1'b0;
    bus.wr_en = 1'b0;
    if (bus.done === 1'b1) begin
      done_count++;
      last_done = cyc;
    end
    checkOutput(tag);
  endtask

  task automatic applyStimulus(input bit st, input bit sp, input bit pa, input string tag);
    bus.start = st;
    bus.stop  = sp;
    bus.pause = pa;
    cycle(tag);
  endtask

  task automatic writeStep(input int addr, input int nt, input int dur, input bit rst);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 3'(addr);
    bus.wr_note = 3'(nt);
    bus.wr_dur  = DUR_W'(dur);
    bus.wr_rest = rst;
    cycle("write");
  endtask

  task automatic run_until_idle(input int budget, input string tag);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < budget) begin
      cycle(tag);
      n++;
    end
    checkValue({tag, "_idle_timeout"}, int'(bus.busy), 0);
  endtask

  task automatic count_gate_high(output int n);
    n = 0;
    while (bus.gate === 1'b1 && n < 200) begin
      n++;
      cycle("gate_len");
    end
  endtask

  initial begin
    int start_cyc, n, r;

    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.pause   = 1'b0;
    bus.loop    = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = 3'd0;
    bus.wr_note = 3'd0;
    bus.wr_dur  = '0;
    bus.wr_rest = 1'b0;
    mode = 0; pos = 0; play_len = 0; step_len = 0;
    cur_step = 0; cur_note = 0; cur_rest = 1'b0; exp_done = 1'b0;

    // Reset defaults, then a full non-looped pass of the default pattern.
    repeat (3) cycle("reset");
    reset = 1'b0;
    cycle("idle");
    applyStimulus(1'b0, 1'b0, 1'b1, "idle_pause");
    done_count = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, "p1_start");
    start_cyc = cyc;
    run_until_idle(400, "p1");
    checkValue("p1_done_time", last_done - start_cyc, STEPS * (8 + GAP_TICKS) * TICK_DIV);
    checkValue("p1_done_count", done_count, 1);
    cycle("p1_after");

    // Rest step with a short duration.
    writeStep(2, 5, 3, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, "p2_start");
    run_until_idle(400, "p2");

    // Looped run over a random pattern, then stop.
    bus.loop = 1'b1;
    for (int i = 0; i < STEPS; i++)
      writeStep(i, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    done_count = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, "p3_start");
    repeat (300) cycle("p3_loop");
    checkValue("p3_no_done", done_count, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, "p3_stop");
    checkValue("p3_state_after_stop", int'(bus.state), 0);
    checkValue("p3_gate_after_stop", int'(bus.gate), 0);
    bus.loop = 1'b0;

    // Pause 10 cycles into step 1, hold, then resume with start.
    reset = 1'b1;
    cycle("p4_reset");
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, "p4_start");
    repeat (49) cycle("p4_play");
    applyStimulus(1'b0, 1'b0, 1'b1, "p4_pause");
    repeat (49) cycle("p4_paused");
    applyStimulus(1'b1, 1'b0, 1'b0, "p4_resume");
    count_gate_high(n);
    checkValue("p4_remaining_gate", n, 8 * TICK_DIV - 10);
    run_until_idle(400, "p4");

    // Simultaneous commands, zero duration, write to the playing step.
    applyStimulus(1'b1, 1'b0, 1'b0, "p5_start");
    repeat (5) cycle("p5_play");
    applyStimulus(1'b1, 1'b1, 1'b1, "p5_all_cmds");
    writeStep(0, 3, 0, 1'b0);
    bus.loop = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, "p5_start2");
    count_gate_high(n);
    checkValue("p5_dur0_len", n, TICK_DIV);
    n = 0;
    while (bus.step !== 3'd2 && n < 200) begin
      cycle("p5_wait_step2");
      n++;
    end
    checkValue("p5_reach_step2", int'(bus.step), 2);
    writeStep(2, 6, 1, 1'b0);
    repeat (400) cycle("p5_loop");
    applyStimulus(1'b0, 1'b1, 1'b0, "p5_stop");

    // Random command and write traffic.
    for (int i = 0; i < 800; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) bus.loop = ~bus.loop;
      if ($urandom_range(0, 3) == 0) begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'($urandom_range(0, 7));
        bus.wr_note = 3'($urandom_range(0, 7));
        bus.wr_dur  = DUR_W'($urandom_range(0, 3));
        bus.wr_rest = 1'($urandom_range(0, 1));
      end
      applyStimulus(r >= 90, r == 50, (r >= 80 && r < 86) || r == 95, "random");
    end

    // Reset mid-gap restores outputs and the default pattern.
    bus.loop = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, "p6_stop");
    applyStimulus(1'b1, 1'b0, 1'b0, "p6_start");
    n = 0;
    while (bus.state !== 2'b10 && n < 200) begin
      cycle("p6_wait_gap");
      n++;
    end
    checkValue("p6_reach_gap", int'(bus.state), 2);
    reset = 1'b1;
    cycle("p6_reset");
    reset = 1'b0;
    done_count = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, "p6_start2");
    start_cyc = cyc;
    run_until_idle(400, "p6");
    checkValue("p6_done_time", last_done - start_cyc, STEPS * (8 + GAP_TICKS) * TICK_DIV);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
